// File: rtl/fx_compressor_mc.sv
// Multi-channel feed-forward compressor; one shared detector/divider/multiplier walks all channels.
// Latency 2*NUM_CH + G*2*DATA_W + 1 cycles (G = 1 linked, NUM_CH independent); strobes while busy are dropped and flagged.
module fx_compressor_mc #(
  parameter int NUM_CH    = 2,
  parameter int DATA_W    = 16,
  parameter int PARAM_W   = 8,
  parameter int LOOKAHEAD = 0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           sample_en,
  input  logic [NUM_CH-1:0][DATA_W-1:0]  audio_in,
  input  logic [PARAM_W-1:0]             fx_threshold,
  input  logic [PARAM_W-1:0]             fx_ratio,
  input  logic [PARAM_W-1:0]             fx_attack,
  input  logic [PARAM_W-1:0]             fx_release,
  input  logic [PARAM_W-1:0]             fx_makeup,
  input  logic                           fx_link,
  output logic [NUM_CH-1:0][DATA_W-1:0]  audio_out,
  output logic                           out_valid,
  output logic                           busy,
  output logic                           overrun,
  output logic [DATA_W-1:0]              gain_out
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int ST_W = $clog2(DATA_W);
  localparam int MK_W = PARAM_W + 8;
  localparam int Z_W  = DATA_W + 1 + MK_W;
  localparam logic [DATA_W-1:0] UNITY = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] AMAX  = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [Z_W-1:0] SMAX = Z_W'(AMAX);
  localparam logic signed [Z_W-1:0] SMIN = ~SMAX;

  typedef enum logic [2:0] {S_IDLE, S_ENV, S_DIVA, S_DIVB, S_APPLY, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CH_W-1:0] ch_q, ch_d, dch_q, dch_d;
  logic [ST_W-1:0] step_q, step_d;
  logic            accept, ch_last, dch_last, step_last;

  logic [NUM_CH-1:0][DATA_W-1:0] x_q, env_q, gain_q, obuf_q, audio_out_q, ap;
  logic [PARAM_W-1:0]            thr_q, ratio_q, att_q, rel_q, mk_q;
  logic                          link_q, overrun_q;
  logic [DATA_W-1:0]             envmax_q, rem_q, quo_q, gmin_q, gain_out_q;

  assign accept    = sample_en && (state_q == S_IDLE);
  assign ch_last   = (ch_q == CH_W'(NUM_CH - 1));
  assign dch_last  = (dch_q == CH_W'(NUM_CH - 1));
  assign step_last = (step_q == ST_W'(DATA_W - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      dch_q   <= '0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      dch_q   <= dch_d;
      step_q  <= step_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    dch_d   = dch_q;
    step_d  = step_q;
    case (state_q)
      S_IDLE: begin
        if (sample_en) begin
          state_d = S_ENV;
          ch_d    = '0;
          dch_d   = '0;
          step_d  = '0;
        end
      end
      S_ENV: begin
        if (ch_last) begin
          ch_d    = '0;
          state_d = S_DIVA;
        end else begin
          ch_d = ch_q + CH_W'(1);
        end
      end
      S_DIVA: begin
        if (step_last) begin
          step_d  = '0;
          state_d = S_DIVB;
        end else begin
          step_d = step_q + ST_W'(1);
        end
      end
      S_DIVB: begin
        if (step_last) begin
          step_d = '0;
          // Independent mode runs one divider pair per channel before applying.
          if (!link_q && !dch_last) begin
            dch_d   = dch_q + CH_W'(1);
            state_d = S_DIVA;
          end else begin
            state_d = S_APPLY;
          end
        end else begin
          step_d = step_q + ST_W'(1);
        end
      end
      S_APPLY: begin
        if (ch_last) begin
          ch_d    = '0;
          state_d = S_DONE;
        end else begin
          ch_d = ch_q + CH_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  generate
    if (LOOKAHEAD == 0) begin : g_nodly
      assign ap = x_q;
    end else begin : g_dly
      localparam int WP_W = (LOOKAHEAD > 1) ? $clog2(LOOKAHEAD) : 1;
      logic [NUM_CH-1:0][DATA_W-1:0] dly_q [LOOKAHEAD];
      logic [NUM_CH-1:0][DATA_W-1:0] ap_q;
      logic [WP_W-1:0]               wp_q;
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < LOOKAHEAD; i++) dly_q[i] <= '0;
          ap_q <= '0;
          wp_q <= '0;
        end else if (accept) begin
          ap_q        <= dly_q[wp_q];
          dly_q[wp_q] <= audio_in;
          wp_q        <= (wp_q == WP_W'(LOOKAHEAD - 1)) ? '0 : wp_q + WP_W'(1);
        end
      end
      assign ap = ap_q;
    end
  endgenerate

  logic [DATA_W-1:0]             xe, a_abs, env_cur, env_diff, env_new, thr_t, lvl, tq;
  logic [DATA_W-1:0]             rem_src, quo_src, rem_nx, quo_nx, g_cur, gmin_nx, zs;
  logic [PARAM_W:0]              coef;
  logic [DATA_W+PARAM_W:0]       prod;
  logic [DATA_W:0]               trial, dvsr;
  logic                          bypass, env_up;
  logic signed [2*DATA_W:0]      p1;
  logic signed [DATA_W:0]        yv;
  logic signed [MK_W-1:0]        mkv;
  logic signed [Z_W-1:0]         p2, zv;
  logic [NUM_CH-1:0][DATA_W-1:0] frame_d;

  assign thr_t = DATA_W'(thr_q) << (DATA_W - 1 - PARAM_W);

  always_comb begin
    xe = x_q[ch_q];
    if (xe == UNITY)        a_abs = AMAX;
    else if (xe[DATA_W-1])  a_abs = -xe;
    else                    a_abs = xe;
    env_cur  = env_q[ch_q];
    env_up   = (a_abs > env_cur);
    env_diff = env_up ? (a_abs - env_cur) : (env_cur - a_abs);
    coef     = env_up ? ({1'b0, att_q} + (PARAM_W+1)'(1)) : ({1'b0, rel_q} + (PARAM_W+1)'(1));
    prod     = (DATA_W+PARAM_W+1)'(env_diff) * (DATA_W+PARAM_W+1)'(coef);
    env_new  = env_up ? (env_cur + DATA_W'(prod >> PARAM_W)) : (env_cur - DATA_W'(prod >> PARAM_W));

    lvl    = link_q ? envmax_q : env_q[dch_q];
    bypass = (lvl <= thr_t) || (ratio_q <= PARAM_W'(1)) || (lvl == '0);
    tq     = thr_t + quo_q;
    // DIVB seeds the remainder with the top of (T+q)<<(DATA_W-1); the quotient is known to fit DATA_W bits.
    if (state_q == S_DIVA) begin
      rem_src = (step_q == '0) ? '0 : rem_q;
      quo_src = (step_q == '0) ? (lvl - thr_t) : quo_q;
      dvsr    = (DATA_W+1)'(ratio_q);
    end else begin
      rem_src = (step_q == '0) ? {1'b0, tq[DATA_W-1:1]} : rem_q;
      quo_src = (step_q == '0) ? {tq[0], {(DATA_W-1){1'b0}}} : quo_q;
      dvsr    = {1'b0, lvl};
    end
    trial = {rem_src, quo_src[DATA_W-1]};
    if (trial >= dvsr) begin
      rem_nx = DATA_W'(trial - dvsr);
      quo_nx = {quo_src[DATA_W-2:0], 1'b1};
    end else begin
      rem_nx = trial[DATA_W-1:0];
      quo_nx = {quo_src[DATA_W-2:0], 1'b0};
    end

    g_cur   = link_q ? gain_q[0] : gain_q[ch_q];
    gmin_nx = ((ch_q == '0) || (g_cur < gmin_q)) ? g_cur : gmin_q;
    p1  = (2*DATA_W+1)'(signed'(ap[ch_q])) * (2*DATA_W+1)'(signed'({1'b0, g_cur}));
    yv  = (DATA_W+1)'(p1 >>> (DATA_W - 1));
    mkv = MK_W'(mk_q) + MK_W'(64);
    p2  = Z_W'(yv) * Z_W'(mkv);
    zv  = p2 >>> 6;
    if (zv > SMAX)      zs = AMAX;
    else if (zv < SMIN) zs = UNITY;
    else                zs = zv[DATA_W-1:0];
    frame_d       = obuf_q;
    frame_d[ch_q] = zs;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_q         <= '0;
      env_q       <= '0;
      gain_q      <= '0;
      obuf_q      <= '0;
      audio_out_q <= '0;
      thr_q       <= '0;
      ratio_q     <= '0;
      att_q       <= '0;
      rel_q       <= '0;
      mk_q        <= '0;
      link_q      <= 1'b0;
      overrun_q   <= 1'b0;
      envmax_q    <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      gmin_q      <= '0;
      gain_out_q  <= UNITY;
    end else begin
      overrun_q <= sample_en && (state_q != S_IDLE);
      if (accept) begin
        x_q     <= audio_in;
        thr_q   <= fx_threshold;
        ratio_q <= fx_ratio;
        att_q   <= fx_attack;
        rel_q   <= fx_release;
        mk_q    <= fx_makeup;
        link_q  <= fx_link;
      end
      case (state_q)
        S_ENV: begin
          env_q[ch_q] <= env_new;
          envmax_q    <= ((ch_q == '0) || (env_new > envmax_q)) ? env_new : envmax_q;
        end
        S_DIVA, S_DIVB: begin
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          if ((state_q == S_DIVB) && step_last) gain_q[dch_q] <= bypass ? UNITY : quo_nx;
        end
        S_APPLY: begin
          obuf_q <= frame_d;
          gmin_q <= gmin_nx;
          if (ch_last) begin
            audio_out_q <= frame_d;
            gain_out_q  <= gmin_nx;
          end
        end
        default: ;
      endcase
    end
  end

  assign audio_out = audio_out_q;
  assign gain_out  = gain_out_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);

endmodule
